// File: rtl/huffman_kodlayici.sv
// huffman_kodlayici: packs Huffman code words followed by amplitude bits into an
// MSB-first byte stream with an end-of-scan flush that pads with 1 bits.
// Optional feature macro: HUFFMAN_BAYT_DOLDURMA_EN (emit 0x00 after every 0xFF byte).
module huffman_kodlayici #(
   parameter int unsigned KOD_BIT  = 16,
   parameter int unsigned VERI_BIT = 11
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [KOD_BIT-1:0]  kd_kod_i,
   input  logic [4:0]          kd_kod_uzunluk_i,
   input  logic [VERI_BIT-1:0] kd_veri_i,
   input  logic                kd_son_i,
   input  logic                kd_gecerli_i,
   output logic                kd_hazir_o,
   output logic [7:0]          m_veri_o,
   output logic                m_gecerli_o,
   input  logic                m_hazir_i
);

   localparam int unsigned SYM_W = KOD_BIT + VERI_BIT;
   localparam int unsigned ACC_W = ((SYM_W + 8) > 40) ? (SYM_W + 8) : 40;
   localparam int unsigned CNT_W = $clog2(ACC_W + 1);
   localparam int unsigned KAT_W = $clog2(VERI_BIT + 2);
   localparam int unsigned ABS_W = VERI_BIT + 1;

   typedef enum logic [1:0] {
      CALIS  = 2'd0,
      DOLDUR = 2'd1,
      BOSALT = 2'd2
   } durum_t;

   durum_t              durum_q, durum_d;
   logic [CNT_W-1:0]    sayac_q, sayac_d, taban_c;
   logic [ACC_W-1:0]    akum_q, akum_d, taban_akum_c;

   logic                negatif_c;
   logic [ABS_W-1:0]    genis_c, mutlak_c;
   logic [KAT_W-1:0]    kat_c;
   logic [VERI_BIT-1:0] genlik_c;
   logic [KOD_BIT-1:0]  kod_c;
   logic [SYM_W-1:0]    sembol_c;
   logic [CNT_W-1:0]    sembol_uz_c, bosluk_c;
   logic [ACC_W-1:0]    alan_c;

   logic                kabul_c, cikis_c, doldur_c;

   assign kabul_c = kd_gecerli_i && kd_hazir_o;
   assign cikis_c = m_gecerli_o && m_hazir_i;

`ifdef HUFFMAN_BAYT_DOLDURMA_EN
   logic donus_q, donus_d;
   assign doldur_c = cikis_c && (durum_q != DOLDUR) && (m_veri_o == 8'hFF);
`else
   assign doldur_c = 1'b0;
`endif

   // Symbol bits left-aligned in an accumulator-wide field, ones below them
   always_comb begin
      negatif_c = kd_veri_i[VERI_BIT-1];
      genis_c   = {negatif_c, kd_veri_i};
      mutlak_c  = negatif_c ? (~genis_c + ABS_W'(1)) : genis_c;
      kat_c     = '0;
      for (int i = 0; i < int'(ABS_W); i++) begin
         if (mutlak_c[i]) kat_c = KAT_W'(i + 1);
      end
      genlik_c    = (negatif_c ? (kd_veri_i - VERI_BIT'(1)) : kd_veri_i)
                    & ~({VERI_BIT{1'b1}} << kat_c);
      kod_c       = kd_kod_i & ~({KOD_BIT{1'b1}} << kd_kod_uzunluk_i);
      sembol_c    = (SYM_W'(kod_c) << kat_c) | SYM_W'(genlik_c);
      sembol_uz_c = CNT_W'(kd_kod_uzunluk_i) + CNT_W'(kat_c);
      bosluk_c    = CNT_W'(ACC_W) - sembol_uz_c;
      alan_c      = (ACC_W'(sembol_c) << bosluk_c) | ({ACC_W{1'b1}} >> sembol_uz_c);
   end

   // Accumulator/count after removing the byte handed out this cycle
   always_comb begin
      taban_akum_c = akum_q;
      taban_c      = sayac_q;
      if (cikis_c) begin
         taban_akum_c = {akum_q[ACC_W-9:0], 8'hFF};
         taban_c      = (sayac_q >= CNT_W'(8)) ? (sayac_q - CNT_W'(8)) : '0;
      end
   end

   // Next-state: append accepted symbols, drain bytes, flush and stuffing
   always_comb begin
      durum_d = durum_q;
      sayac_d = sayac_q;
      akum_d  = akum_q;
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
      donus_d = donus_q;
`endif
      case (durum_q)
         CALIS: begin
            akum_d  = taban_akum_c;
            sayac_d = taban_c;
            if (kabul_c) begin
               // bits below the valid region are always ones, so AND inserts the field
               akum_d  = taban_akum_c & ~((~alan_c) >> taban_c);
               sayac_d = taban_c + sembol_uz_c;
               if (kd_son_i) durum_d = BOSALT;
            end
            if (doldur_c) begin
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
               donus_d = (durum_d == BOSALT);
`endif
               durum_d = DOLDUR;
            end
         end
         BOSALT: begin
            akum_d  = taban_akum_c;
            sayac_d = taban_c;
            if (sayac_q == '0) begin
               durum_d = CALIS;
            end else if (doldur_c) begin
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
               donus_d = 1'b1;
`endif
               durum_d = DOLDUR;
            end
         end
         DOLDUR: begin
            if (cikis_c) begin
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
               durum_d = donus_q ? BOSALT : CALIS;
`else
               durum_d = CALIS;
`endif
            end
         end
         default: durum_d = CALIS;
      endcase
   end

   // State, accumulator and registered handshake/data outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_q     <= CALIS;
         sayac_q     <= '0;
         akum_q      <= '1;
         kd_hazir_o  <= 1'b0;
         m_gecerli_o <= 1'b0;
         m_veri_o    <= 8'h00;
      end else begin
         durum_q     <= durum_d;
         sayac_q     <= sayac_d;
         akum_q      <= akum_d;
         kd_hazir_o  <= (durum_d == CALIS) && (sayac_d < CNT_W'(8));
         m_gecerli_o <= (durum_d == DOLDUR) || (sayac_d >= CNT_W'(8))
                        || ((durum_d == BOSALT) && (sayac_d != '0));
         m_veri_o    <= (durum_d == DOLDUR) ? 8'h00 : akum_d[ACC_W-1 -: 8];
      end
   end

`ifdef HUFFMAN_BAYT_DOLDURMA_EN
   // Remembers whether a stuff byte interrupted normal operation or a flush
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) donus_q <= 1'b0;
      else         donus_q <= donus_d;
   end
`endif

endmodule

// File: tb/tb_huffman_kodlayici.sv
// Directed self-checking bench for huffman_kodlayici.
module tb_huffman_kodlayici;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] kd_kod = '0;
   logic [4:0]  kd_len = '0;
   logic [10:0] kd_veri = '0;
   logic        kd_son = 1'b0;
   logic        kd_gecerli = 1'b0;
   logic        kd_hazir;
   logic [7:0]  m_veri;
   logic        m_gecerli;
   logic        m_hazir = 1'b1;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  got_q[$];

   huffman_kodlayici #(.KOD_BIT(16), .VERI_BIT(11)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .kd_kod_i         (kd_kod),
      .kd_kod_uzunluk_i (kd_len),
      .kd_veri_i        (kd_veri),
      .kd_son_i         (kd_son),
      .kd_gecerli_i     (kd_gecerli),
      .kd_hazir_o       (kd_hazir),
      .m_veri_o         (m_veri),
      .m_gecerli_o      (m_gecerli),
      .m_hazir_i        (m_hazir)
   );

   always #5 clk = ~clk;

   // byte handshakes are sampled mid-cycle, inputs change just after posedge
   always @(negedge clk) begin
      if (rstn && m_gecerli && m_hazir) got_q.push_back(m_veri);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [15:0] kod, input int len, input int veri, input logic son);
      int t;
      t = 0;
      kd_kod     = kod;
      kd_len     = 5'(len);
      kd_veri    = 11'(veri);
      kd_son     = son;
      kd_gecerli = 1'b1;
      @(negedge clk);
      while (!kd_hazir && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         total++;
         bad++;
         $display("FAIL send_timeout: kd_hazir_o=%b required 1", kd_hazir);
      end
      @(posedge clk);
      #1;
      kd_gecerli = 1'b0;
      kd_son     = 1'b0;
   endtask

   function automatic int sym_veri(input int i);
      if (i == 7)  return -1024;
      if (i == 13) return 1023;
      if (i == 20) return 0;
      return ((i * 37) % 41) - 20;
   endfunction

   task automatic test_reset();
      step(2);
      total++; if (kd_hazir !== 1'b0) begin bad++; $display("FAIL rst_hazir: got %b need 0", kd_hazir); end
      total++; if (m_gecerli !== 1'b0) begin bad++; $display("FAIL rst_gecerli: got %b need 0", m_gecerli); end
      total++; if (m_veri !== 8'h00) begin bad++; $display("FAIL rst_veri: got %h need 00", m_veri); end
      rstn = 1'b1;
      step(1);
      total++; if (kd_hazir !== 1'b1) begin bad++; $display("FAIL post_rst_hazir: got %b need 1", kd_hazir); end
      total++; if (m_gecerli !== 1'b0) begin bad++; $display("FAIL post_rst_gecerli: got %b need 0", m_gecerli); end
   endtask

   task automatic test_two_symbols();
      logic [7:0] exp_q[$];
      logic [7:0] g;
      got_q.delete();
      send_sym(16'b00, 2, 0, 1'b0);
      send_sym(16'b1010, 4, 0, 1'b1);
      step(10);
      exp_q = '{8'h2B};
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t2b_count: got %0d need %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL t2b_byte%0d: got %h need %h", i, g, exp_q[i]); end
      end
      total++; if (m_gecerli !== 1'b0) begin bad++; $display("FAIL t2b_idle_gecerli: got %b need 0", m_gecerli); end
      total++; if (kd_hazir !== 1'b1) begin bad++; $display("FAIL t2b_idle_hazir: got %b need 1", kd_hazir); end
   endtask

   task automatic test_negative_amp();
      logic [7:0] exp_q[$];
      logic [7:0] g;
      got_q.delete();
      send_sym(16'b100, 3, -3, 1'b0);
      send_sym(16'b1010, 4, 0, 1'b1);
      step(10);
      exp_q = '{8'h85, 8'h7F};
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL neg_count: got %0d need %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL neg_byte%0d: got %h need %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_stuffing();
      logic [7:0] exp_q[$];
      logic [7:0] g;
      got_q.delete();
      send_sym(16'hFF, 8, 0, 1'b1);
      step(10);
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
      exp_q = '{8'hFF, 8'h00};
`else
      exp_q = '{8'hFF};
`endif
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stuff_count: got %0d need %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL stuff_byte%0d: got %h need %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_min_value();
      logic [7:0] exp_q[$];
      logic [7:0] g;
      got_q.delete();
      send_sym(16'h0, 0, -1024, 1'b1);
      step(10);
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
      exp_q = '{8'h7F, 8'hFF, 8'h00};
`else
      exp_q = '{8'h7F, 8'hFF};
`endif
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL minv_count: got %0d need %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL minv_byte%0d: got %h need %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_zero_flush();
      logic [7:0] g;
      got_q.delete();
      send_sym(16'h0, 0, 0, 1'b1);
      step(3);
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL zflush_count: got %0d need 0", got_q.size()); end
      total++; if (kd_hazir !== 1'b1) begin bad++; $display("FAIL zflush_hazir: got %b need 1", kd_hazir); end
      send_sym(16'b01, 2, 0, 1'b1);
      step(10);
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL zflush_after_count: got %0d need 1", got_q.size()); end
      g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      total++; if (g !== 8'h7F) begin bad++; $display("FAIL zflush_after_byte: got %h need 7F", g); end
   endtask

   // 30-symbol stream against a bit-queue model; bp=1 stalls the byte side for 5 cycles
   task automatic test_stream(input logic bp);
      bit         mb[$];
      logic [7:0] exp_q[$];
      logic [7:0] g, bv, pb;
      logic [15:0] kod;
      int         len, v, a, cat, amp;
      logic       pv, saw;
      for (int i = 0; i < 30; i++) begin
         kod = 16'(i * 40503 + 7);
         len = 2 + (i % 15);
         v   = sym_veri(i);
         for (int b = len - 1; b >= 0; b--) mb.push_back(kod[b]);
         a   = (v < 0) ? -v : v;
         cat = 0;
         while ((a >> cat) != 0) cat++;
         amp = (v > 0) ? v : v - 1;
         for (int b = cat - 1; b >= 0; b--) mb.push_back(amp[b]);
      end
      while ((mb.size() % 8) != 0) mb.push_back(1'b1);
      for (int k = 0; k < mb.size(); k += 8) begin
         bv = '0;
         for (int j = 0; j < 8; j++) bv = {bv[6:0], mb[k + j]};
         exp_q.push_back(bv);
`ifdef HUFFMAN_BAYT_DOLDURMA_EN
         if (bv == 8'hFF) exp_q.push_back(8'h00);
`endif
      end
      got_q.delete();
      pv = 1'b0; pb = '0; saw = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++)
               send_sym(16'(i * 40503 + 7), 2 + (i % 15), sym_veri(i), i == 29);
         end
         begin
            if (bp) begin
               step(8);
               m_hazir = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  if (!kd_hazir) saw = 1'b1;
                  if (pv) begin
                     total++;
                     if (m_gecerli !== 1'b1 || m_veri !== pb) begin
                        bad++;
                        $display("FAIL bp_hold: got v=%b d=%h need v=1 d=%h", m_gecerli, m_veri, pb);
                     end
                  end
                  pv = m_gecerli;
                  pb = m_veri;
               end
               @(posedge clk);
               #1;
               m_hazir = 1'b1;
               total++; if (!saw) begin bad++; $display("FAIL bp_hazir_drop: got kd_hazir_o never 0 need 0"); end
            end
         end
      join
      step(40);
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stream%0d_count: got %0d need %0d", bp, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         total++; if (g !== exp_q[i]) begin bad++; $display("FAIL stream%0d_byte%0d: got %h need %h", bp, i, g, exp_q[i]); end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] g;
      m_hazir = 1'b0;
      got_q.delete();
      send_sym(16'hABC, 12, 0, 1'b0);
      step(2);
      total++; if (m_gecerli !== 1'b1) begin bad++; $display("FAIL mrst_pre_gecerli: got %b need 1", m_gecerli); end
      total++; if (m_veri !== 8'hAB) begin bad++; $display("FAIL mrst_pre_veri: got %h need AB", m_veri); end
      #3;
      rstn = 1'b0;
      #1;
      total++; if (kd_hazir !== 1'b0) begin bad++; $display("FAIL mrst_hazir: got %b need 0", kd_hazir); end
      total++; if (m_gecerli !== 1'b0) begin bad++; $display("FAIL mrst_gecerli: got %b need 0", m_gecerli); end
      total++; if (m_veri !== 8'h00) begin bad++; $display("FAIL mrst_veri: got %h need 00", m_veri); end
      step(1);
      rstn = 1'b1;
      m_hazir = 1'b1;
      got_q.delete();
      send_sym(16'b00, 2, 0, 1'b1);
      step(10);
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL mrst_after_count: got %0d need 1", got_q.size()); end
      g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      total++; if (g !== 8'h3F) begin bad++; $display("FAIL mrst_after_byte: got %h need 3F", g); end
   endtask

   initial begin
      test_reset();
      test_two_symbols();
      test_negative_amp();
      test_stuffing();
      test_min_value();
      test_zero_flush();
      test_stream(1'b0);
      test_stream(1'b1);
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/huffman_kodlayici.md
HUFFMAN_KODLAYICI -- requirements
Module: huffman_kodlayici

Interface
REQ-001 SHALL have parameter KOD_BIT, default 16: maximum Huffman code word length.
REQ-002 SHALL have parameter VERI_BIT, default 11 (=`HDATA_BIT): signed coefficient width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port kd_kod_i, input, KOD_BIT: Huffman code word, right-aligned, MSB transmitted first.
REQ-006 SHALL have port kd_kod_uzunluk_i, input, 5: code length, 0..16; 0 appends amplitude bits only.
REQ-007 SHALL have port kd_veri_i, input, VERI_BIT: signed two's-complement coefficient, -1024..1023.
REQ-008 SHALL have port kd_son_i, input, 1: last symbol of the scan; qualified by the input handshake.
REQ-009 SHALL have ports kd_gecerli_i (input, 1) and kd_hazir_o (output, 1): symbol valid/ready.
REQ-010 SHALL have port m_veri_o, output, 8: output bitstream byte, first bit in bit 7.
REQ-011 SHALL have ports m_gecerli_o (output, 1) and m_hazir_i (input, 1): byte valid/ready.

Function
REQ-012 SHALL accept a symbol only on a cycle with kd_gecerli_i && kd_hazir_o, and emit a byte only on a cycle with m_gecerli_o && m_hazir_i.
REQ-013 SHALL compute category cat = 0 for kd_veri_i == 0, else the bit length of |kd_veri_i| (1..11).
REQ-014 SHALL compute amplitude bits: kd_veri_i[cat-1:0] if positive, (kd_veri_i-1)[cat-1:0] if negative, none if cat == 0.
REQ-015 SHALL append the code bits, then the amplitude bits, MSB-first to a bit accumulator of at least 40 bits, with a bit count register.
REQ-016 SHALL drive kd_hazir_o = 1 only in state CALIS with bit count < 8.
REQ-017 SHALL drive m_gecerli_o = 1 when bit count >= 8 (states CALIS/BOSALT) or in state DOLDUR; m_veri_o = top 8 accumulator bits, or 0x00 in DOLDUR.
REQ-018 SHALL, on a cycle with both an accept and an emit, update count = count - 8 + kod_uzunluk + cat, with no lost or duplicated bit.
REQ-019 SHALL make the first byte containing the bits of a symbol accepted in cycle N valid no earlier than cycle N+1 (registered outputs only).
REQ-020 SHALL implement states CALIS (normal), DOLDUR (stuff byte pending), BOSALT (end-of-scan flush).
REQ-021 SHALL transition CALIS->BOSALT on accepting a symbol with kd_son_i = 1.
REQ-022 SHALL, in BOSALT, pad a partial final byte with 1 bits to the byte boundary, emit all remaining bytes, then return to CALIS with count 0.
REQ-023 SHALL hold m_veri_o and m_gecerli_o stable while m_gecerli_o && !m_hazir_i.
REQ-024 SHALL, for a flush with count 0, emit no byte and return to CALIS on the next cycle.

Reset
REQ-025 SHALL, while rstn_i = 0, asynchronously force state CALIS, count 0, accumulator all-ones, kd_hazir_o 0, m_gecerli_o 0, m_veri_o 0x00.
REQ-026 SHALL discard all partial bits when reset is asserted mid-operation; the first byte after reset contains only post-reset symbols.

Configuration
REQ-027 SHALL, with macro HUFFMAN_BAYT_DOLDURMA_EN defined, enter DOLDUR after every emitted 0xFF byte (flush bytes included) and emit 0x00 before any further byte, without changing count.
REQ-028 SHALL, without HUFFMAN_BAYT_DOLDURMA_EN, never enter DOLDUR and emit the raw packed bitstream.

Verification
REQ-029 SHALL verify: {kod=2'b00, len 2, veri 0}, then {kod=4'b1010, len 4, veri 0, son=1} -> single byte 0x2B, then idle.
REQ-030 SHALL verify: {kod=3'b100, len 3, veri -3}, then {kod=4'b1010, len 4, veri 0, son=1} -> bytes 0x85, 0x7F.
REQ-031 SHALL verify: {kod=8'hFF, len 8, veri 0, son=1} -> 0xFF, 0x00 with HUFFMAN_BAYT_DOLDURMA_EN; 0xFF only without it.
REQ-032 SHALL verify: {kod=0, len 0, veri -1024, son=1} -> bytes 0x7F, 0xFF (amplitude 01111111111 plus 1-bit padding).
REQ-033 SHALL verify: m_hazir_i = 0 for 5 cycles during a 30-symbol stream -> kd_hazir_o drops, m_veri_o is held, and the byte stream equals the no-backpressure golden stream.
REQ-034 SHALL verify: rstn_i pulsed low with count = 12 -> outputs at reset values within the same cycle, and no stale byte afterwards.
